// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX path: TX output mux select encodings and frame FSM states.
// UART_TX_PARITY_EN enables the optional parity slot.
package uart_tx_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // The select value that the mux must see while the FSM is in state s.
  function automatic logic [1:0] sel_of(input tx_state_t s);
    logic [1:0] sel;
    sel = SEL_STOP;
    case (s)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  sel = SEL_PAR;
`endif
      default: sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register with bit counter. ser_out shows bit 0 right after load, and each shift advances one bit.
// done flags that the last payload bit is on ser_out.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_out,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  // cnt is the index of the bit currently presented on ser_out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      cnt     <= '0;
      ser_out <= 1'b0;
    end else if (load) begin
      ser_out <= data_in[0];
      shreg   <= data_in >> 1;
      cnt     <= '0;
    end else if (shift) begin
      ser_out <= shreg[0];
      shreg   <= shreg >> 1;
      cnt     <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: runs the frame FSM, drives the registered mux select, serial data and parity bit.
// Define UART_TX_PARITY_EN to include the parity slot. Without it, PAR_EN and PAR_TYP are ignored.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  SER_DATA,
  output logic                  par_bit,
  output logic                  busy
);

  tx_state_t state, next_state;
  logic      load, shift, done;
  logic      par_en_q;

  assign load  = (state == IDLE) && Data_Valid;
  assign shift = (state == DATA) && !done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk     (CLK),
    .rst     (RST),
    .load    (load),
    .shift   (shift),
    .data_in (P_DATA),
    .ser_out (SER_DATA),
    .done    (done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Data_Valid) next_state = START;
      START:   next_state = DATA;
      DATA:    if (done) next_state = par_en_q ? PARITY : STOP;
`ifdef UART_TX_PARITY_EN
      PARITY:  next_state = STOP;
`endif
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state, so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mux_sel <= SEL_STOP;
      busy    <= 1'b0;
    end else begin
      mux_sel <= sel_of(next_state);
      busy    <= (next_state != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is computed once at acceptance and then held until the next acceptance.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else if (load) begin
      par_en_q <= PAR_EN;
      par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end
  end
`else
  logic unused_par;
  assign unused_par = ^{PAR_EN, PAR_TYP};
  assign par_en_q   = 1'b0;
  assign par_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl.
// Expectations follow UART_TX_PARITY_EN: when it is undefined, there is no parity slot and par_bit stays 0.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [1:0]    mux_sel;
  logic          SER_DATA;
  logic          par_bit;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [1:0] cap_sel  [64];
  logic       cap_ser  [64];
  logic       cap_busy [64];
  logic       cap_par  [64];

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .SER_DATA   (SER_DATA),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Records n post-edge samples. Data_Valid drops after sample dv_last; a one-cycle pulse of pulse_val is injected after sample pulse_idx.
  task automatic capture(input int n, input int dv_last, input int pulse_idx, input logic [DW-1:0] pulse_val);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      cap_sel[i]  = mux_sel;
      cap_ser[i]  = SER_DATA;
      cap_busy[i] = busy;
      cap_par[i]  = par_bit;
      if (i == pulse_idx) begin
        Data_Valid = 1'b1;
        P_DATA     = pulse_val;
      end else if (i >= dv_last) begin
        Data_Valid = 1'b0;
      end
    end
  endtask

  // Expected select at sample j after acceptance (j = 0 is the acceptance edge).
  function automatic logic [1:0] exp_sel(input int j, input bit par);
    if (j == 0)               return 2'b00;
    if (j <= DW)              return 2'b10;
    if (par && j == DW + 1)   return 2'b11;
    return 2'b01;
  endfunction

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      checks++; if (mux_sel !== 2'b01) begin failures++; $display("FAIL reset_sel[%0d] got=%b exp=01", c, mux_sel); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", c, busy); end
      checks++; if (SER_DATA !== 1'b0) begin failures++; $display("FAIL reset_ser[%0d] got=%b exp=0", c, SER_DATA); end
      checks++; if (par_bit !== 1'b0) begin failures++; $display("FAIL reset_par[%0d] got=%b exp=0", c, par_bit); end
    end
    RST = 1'b1; Data_Valid = 1'b0;
    @(posedge CLK); #1;
    checks++; if (mux_sel !== 2'b01 || busy !== 1'b0) begin failures++; $display("FAIL reset_release got=%b/%b exp=01/0", mux_sel, busy); end
  endtask

  task automatic test_parity_even();
    logic [DW-1:0] d = 8'hA5;
    int L = DW + 2 + int'(PAR_ON);
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    capture(L + 1, 0, -1, '0);
    for (int i = 0; i <= L; i++) begin
      checks++; if (cap_sel[i] !== exp_sel(i, PAR_ON)) begin failures++; $display("FAIL even_sel[%0d] got=%b exp=%b", i, cap_sel[i], exp_sel(i, PAR_ON)); end
      checks++; if (cap_busy[i] !== (i < L)) begin failures++; $display("FAIL even_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < L); end
      checks++; if (cap_par[i] !== 1'b0) begin failures++; $display("FAIL even_par[%0d] got=%b exp=0", i, cap_par[i]); end
      if (i >= 1 && i <= DW) begin
        checks++; if (cap_ser[i] !== d[i-1]) begin failures++; $display("FAIL even_ser[%0d] got=%b exp=%b", i, cap_ser[i], d[i-1]); end
      end
    end
  endtask

  task automatic test_odd_parity();
    logic [DW-1:0] vals [2] = '{8'h01, 8'h03};
    logic          exp_p[2] = '{1'b0, PAR_ON};
    int L = DW + 2 + int'(PAR_ON);
    for (int v = 0; v < 2; v++) begin
      int nbusy = 0;
      P_DATA = vals[v]; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      capture(L + 1, 0, -1, '0);
      for (int i = 0; i <= L; i++) begin
        if (cap_busy[i] === 1'b1) nbusy++;
        checks++; if (cap_par[i] !== exp_p[v]) begin failures++; $display("FAIL odd_par_%0d[%0d] got=%b exp=%b", v, i, cap_par[i], exp_p[v]); end
      end
      checks++; if (cap_sel[DW+1] !== exp_sel(DW + 1, PAR_ON)) begin failures++; $display("FAIL odd_slot_%0d got=%b exp=%b", v, cap_sel[DW+1], exp_sel(DW + 1, PAR_ON)); end
      checks++; if (nbusy != L) begin failures++; $display("FAIL odd_len_%0d got=%0d exp=%0d", v, nbusy, L); end
    end
  endtask

  task automatic test_no_parity_ignore();
    int L = DW + 2;
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    capture(L + 3, 0, 4, 8'h00);
    for (int i = 0; i < L + 3; i++) begin
      checks++; if (cap_sel[i] !== exp_sel(i, 1'b0)) begin failures++; $display("FAIL nopar_sel[%0d] got=%b exp=%b", i, cap_sel[i], exp_sel(i, 1'b0)); end
      checks++; if (cap_busy[i] !== (i < L)) begin failures++; $display("FAIL nopar_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < L); end
      if (i >= 1 && i <= DW) begin
        checks++; if (cap_ser[i] !== 1'b1) begin failures++; $display("FAIL nopar_ser[%0d] got=%b exp=1", i, cap_ser[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d = 8'h3C;
    int L = DW + 2 + int'(PAR_ON);
    int n = 2 * (L + 1);
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    capture(n, n - 1, -1, '0);
    for (int i = 0; i < n; i++) begin
      int j = i % (L + 1);
      checks++; if (cap_sel[i] !== exp_sel(j, PAR_ON)) begin failures++; $display("FAIL b2b_sel[%0d] got=%b exp=%b", i, cap_sel[i], exp_sel(j, PAR_ON)); end
      checks++; if (cap_busy[i] !== (j < L)) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, cap_busy[i], j < L); end
      if (j >= 1 && j <= DW) begin
        checks++; if (cap_ser[i] !== d[j-1]) begin failures++; $display("FAIL b2b_ser[%0d] got=%b exp=%b", i, cap_ser[i], d[j-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d0 = 8'hC3;
    logic [DW-1:0] d1 = 8'h5A;
    int L = DW + 2 + int'(PAR_ON);
    P_DATA = d0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    capture(6, 0, -1, '0);
    checks++; if (cap_sel[5] !== 2'b10 || cap_ser[5] !== d0[4]) begin failures++; $display("FAIL mid_bit4 got=%b/%b exp=10/%b", cap_sel[5], cap_ser[5], d0[4]); end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (mux_sel !== 2'b01) begin failures++; $display("FAIL mid_rst_sel got=%b exp=01", mux_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (SER_DATA !== 1'b0 || par_bit !== 1'b0) begin failures++; $display("FAIL mid_rst_ser_par got=%b/%b exp=0/0", SER_DATA, par_bit); end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (mux_sel !== 2'b01 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b exp=01/0", mux_sel, busy); end
    P_DATA = d1; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    capture(L + 1, 0, -1, '0);
    for (int i = 0; i <= L; i++) begin
      checks++; if (cap_sel[i] !== exp_sel(i, PAR_ON)) begin failures++; $display("FAIL post_sel[%0d] got=%b exp=%b", i, cap_sel[i], exp_sel(i, PAR_ON)); end
      checks++; if (cap_busy[i] !== (i < L)) begin failures++; $display("FAIL post_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < L); end
      checks++; if (cap_par[i] !== PAR_ON) begin failures++; $display("FAIL post_par[%0d] got=%b exp=%b", i, cap_par[i], PAR_ON); end
      if (i >= 1 && i <= DW) begin
        checks++; if (cap_ser[i] !== d1[i-1]) begin failures++; $display("FAIL post_ser[%0d] got=%b exp=%b", i, cap_ser[i], d1[i-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_odd_parity();
    test_no_parity_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
